dccm_bank_mem: RTL and testbench
================================

Name: dccm_bank_mem

Overview:
- Parametrised, banked closely-coupled data memory. Successor to the fixed single-instance DCCM wrapper, generalised in bank count, width and depth.
- Adds per-bank read/write conflict arbitration and a one-entry-per-bank pending-write buffer with read forwarding. Also adds a freeze hold and lo/hi same-bank retry.
- Sits between the LSU DC2/DC3 pipeline and the per-bank SRAM arrays, which are modelled internally as flop arrays.

Parameters:
- DATA_WIDTH, 39, word width including ECC bits.
- ADDR_BITS, 16, byte-address width.
- NUM_BANKS, 4, bank count; power of 2, minimum 2.
- BANK_BITS, log2(NUM_BANKS), derived; bank = addr[2+BANK_BITS-1:2].
- ROW_BITS, ADDR_BITS-2-BANK_BITS, derived; row = addr[ADDR_BITS-1:2+BANK_BITS].

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- freeze  in  1  hold read outputs; block new read launches.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_BITS  write byte address.
- wr_data  in  DATA_WIDTH  write word.
- wr_ready  out  1  write is accepted this cycle when wr_en && wr_ready (combinational).
- rd_en  in  1  read request (lo and hi together).
- rd_addr_lo  in  ADDR_BITS  low read address.
- rd_addr_hi  in  ADDR_BITS  high read address.
- rd_data_lo  out  DATA_WIDTH  registered low read data.
- rd_data_hi  out  DATA_WIDTH  registered high read data.
- rd_valid  out  1  rd_data_* valid.
- rd_hi_retry  out  1  hi read was not served; requester must reissue.
- pend_busy  out  1  OR of all pending-buffer valid bits.

Behaviour:
- Reset: rd_data_lo/hi=0, rd_valid=0, rd_hi_retry=0, all pend_valid=0 (pending writes are dropped), pend_busy=0. Array contents are not reset.
- Read launch: a read launches at cycle T when rd_en && !freeze. Data appears at T+1 with rd_valid=1. If no launch at T and !freeze, rd_valid=0 at T+1.
- Freeze: rd_data_*, rd_valid and rd_hi_retry hold their values. rd_en is ignored. Writes and retires continue.
- lo/hi same bank, same row: both outputs receive the same word.
- lo/hi same bank, different row: lo is served. At T+1 rd_hi_retry=1 and rd_data_hi holds its previous value.
- Bank "read-busy" at T: a launched read (lo, or hi if served) targets that bank.
- Per-bank state IDLE/PEND (pend_valid, pend_row, pend_data):
  - Write to a bank that is not read-busy, IDLE: write array directly; state stays IDLE.
  - Write to a bank that is not read-busy, PEND: retire the pending entry to the array; capture the new write into pending; state stays PEND. This preserves write order.
  - Write to a read-busy bank, IDLE: capture into pending; IDLE->PEND.
  - Write to a read-busy bank, PEND: wr_ready=0; the write is not accepted.
  - No write, bank PEND and not read-busy: retire; PEND->IDLE.
- wr_ready = !(pend_valid[wbank] && read_busy[wbank]).
- Forwarding: a read whose bank/row matches a pending entry valid at the start of T returns pend_data.
- Same-cycle write to the same row as a read returns the pre-write value.
- pend_busy is registered from the pend_valid bits.
- rst mid-operation overrides all other events in that cycle.

Test Plan:
- Write 0x12 to addr 0x0004 (bank1) with no read; read 0x0004 next cycle -> rd_valid=1 at T+1, rd_data_lo=0x12, pend_busy stays 0.
- Read lo=0x0008 and write 0x55 to 0x0018 (both bank2) in one cycle -> wr_ready=1, pend_busy=1 next cycle. Idle cycle -> pend_busy=0; read 0x0018 returns 0x55.
- Hold bank2 read-busy with a pending entry; write to bank2 -> wr_ready=0, write dropped. Release the read -> retire occurs; reissued write is accepted.
- Pending 0x77 at 0x0018; read 0x0018 while the bank is read-busy -> rd_data_lo=0x77 (forwarded).
- lo=0x0004, hi=0x0014 (bank1, rows 0/1) -> rd_hi_retry=1 at T+1, rd_data_lo is the correct word. lo=hi=0x0004 -> both outputs equal, retry=0.
- Read, then freeze=1 for 3 cycles with rd_en=1 -> outputs frozen. rst with pending valid -> pend_busy=0, rd_valid=0 next cycle; that write is lost.

Source files
------------

// File: rtl/dccm_bank_mem.sv
// Banked closely-coupled data memory: per-bank flop arrays, read/write conflict
// arbitration, a one-entry pending-write buffer per bank with read forwarding.
module dccm_bank_mem #(
    parameter int unsigned DATA_WIDTH = 39,
    parameter int unsigned ADDR_BITS  = 16,
    parameter int unsigned NUM_BANKS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr_lo,
    input  logic [ADDR_BITS-1:0]  rd_addr_hi,
    output logic [DATA_WIDTH-1:0] rd_data_lo,
    output logic [DATA_WIDTH-1:0] rd_data_hi,
    output logic                  rd_valid,
    output logic                  rd_hi_retry,
    output logic                  pend_busy
);

    localparam int unsigned BANK_BITS = $clog2(NUM_BANKS);
    localparam int unsigned ROW_BITS  = ADDR_BITS - 2 - BANK_BITS;
    localparam int unsigned NUM_ROWS  = 1 << ROW_BITS;

    typedef logic [BANK_BITS-1:0]  bank_t;
    typedef logic [ROW_BITS-1:0]   row_t;
    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef enum logic {IDLE, PEND} pend_state_e;

    // Address decode
    bank_t wr_bank, lo_bank, hi_bank;
    row_t  wr_row, lo_row, hi_row;
    logic  unused_addr_bits;

    assign wr_bank = wr_addr[2 +: BANK_BITS];
    assign lo_bank = rd_addr_lo[2 +: BANK_BITS];
    assign hi_bank = rd_addr_hi[2 +: BANK_BITS];
    assign wr_row  = wr_addr[2+BANK_BITS +: ROW_BITS];
    assign lo_row  = rd_addr_lo[2+BANK_BITS +: ROW_BITS];
    assign hi_row  = rd_addr_hi[2+BANK_BITS +: ROW_BITS];
    assign unused_addr_bits = ^{wr_addr[1:0], rd_addr_lo[1:0], rd_addr_hi[1:0]};

    // Storage and per-bank pending-buffer state
    word_t       mem_q       [NUM_BANKS][NUM_ROWS];
    pend_state_e state_q     [NUM_BANKS];
    pend_state_e state_d     [NUM_BANKS];
    row_t        pend_row_q  [NUM_BANKS];
    row_t        pend_row_d  [NUM_BANKS];
    word_t       pend_data_q [NUM_BANKS];
    word_t       pend_data_d [NUM_BANKS];

    logic        arr_we      [NUM_BANKS];
    row_t        arr_row     [NUM_BANKS];
    word_t       arr_data    [NUM_BANKS];

    logic                 launch;
    logic                 hi_conflict;
    logic                 hi_served;
    logic [NUM_BANKS-1:0] read_busy;
    logic [NUM_BANKS-1:0] wr_hit;
    logic                 pend_busy_d, pend_busy_q;

    word_t lo_word, hi_word;
    word_t rd_data_lo_d, rd_data_lo_q;
    word_t rd_data_hi_d, rd_data_hi_q;
    logic  rd_valid_d, rd_valid_q;
    logic  rd_hi_retry_d, rd_hi_retry_q;

    assign launch      = rd_en && !freeze;
    assign hi_conflict = (lo_bank == hi_bank) && (lo_row != hi_row);
    assign hi_served   = launch && !hi_conflict;

    // A bank is read-busy when a launched read port targets it
    always_comb begin
        read_busy = '0;
        wr_hit    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            read_busy[b] = (launch && (lo_bank == bank_t'(b)))
                        || (hi_served && (hi_bank == bank_t'(b)));
            wr_hit[b]    = wr_en && (wr_bank == bank_t'(b));
        end
    end

    assign wr_ready = !((state_q[wr_bank] == PEND) && read_busy[wr_bank]);

    // Per-bank IDLE/PEND next state and array write port selection
    always_comb begin
        pend_busy_d = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            state_d[b]     = state_q[b];
            pend_row_d[b]  = pend_row_q[b];
            pend_data_d[b] = pend_data_q[b];
            arr_we[b]      = 1'b0;
            arr_row[b]     = wr_row;
            arr_data[b]    = wr_data;
            unique case (state_q[b])
                IDLE: begin
                    if (wr_hit[b]) begin
                        if (read_busy[b]) begin
                            state_d[b]     = PEND;
                            pend_row_d[b]  = wr_row;
                            pend_data_d[b] = wr_data;
                        end else begin
                            arr_we[b] = 1'b1;
                        end
                    end
                end
                PEND: begin
                    // Retire before accepting a new write keeps write order
                    if (!read_busy[b]) begin
                        arr_we[b]   = 1'b1;
                        arr_row[b]  = pend_row_q[b];
                        arr_data[b] = pend_data_q[b];
                        if (wr_hit[b]) begin
                            pend_row_d[b]  = wr_row;
                            pend_data_d[b] = wr_data;
                        end else begin
                            state_d[b] = IDLE;
                        end
                    end
                end
                default: state_d[b] = IDLE;
            endcase
            pend_busy_d = pend_busy_d | (state_d[b] == PEND);
        end
    end

    // Read data with forwarding from entries pending at the start of the cycle
    always_comb begin
        lo_word = mem_q[lo_bank][lo_row];
        hi_word = mem_q[hi_bank][hi_row];
        if ((state_q[lo_bank] == PEND) && (pend_row_q[lo_bank] == lo_row)) begin
            lo_word = pend_data_q[lo_bank];
        end
        if ((state_q[hi_bank] == PEND) && (pend_row_q[hi_bank] == hi_row)) begin
            hi_word = pend_data_q[hi_bank];
        end
    end

    // Read output next state; freeze holds everything
    always_comb begin
        rd_data_lo_d  = rd_data_lo_q;
        rd_data_hi_d  = rd_data_hi_q;
        rd_valid_d    = rd_valid_q;
        rd_hi_retry_d = rd_hi_retry_q;
        if (launch) begin
            rd_valid_d    = 1'b1;
            rd_data_lo_d  = lo_word;
            rd_hi_retry_d = hi_conflict;
            if (!hi_conflict) begin
                rd_data_hi_d = hi_word;
            end
        end else if (!freeze) begin
            rd_valid_d    = 1'b0;
            rd_hi_retry_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= IDLE;
            end
            pend_busy_q   <= 1'b0;
            rd_data_lo_q  <= '0;
            rd_data_hi_q  <= '0;
            rd_valid_q    <= 1'b0;
            rd_hi_retry_q <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= state_d[b];
            end
            pend_busy_q   <= pend_busy_d;
            rd_data_lo_q  <= rd_data_lo_d;
            rd_data_hi_q  <= rd_data_hi_d;
            rd_valid_q    <= rd_valid_d;
            rd_hi_retry_q <= rd_hi_retry_d;
        end
    end

    // Pending payload is qualified by state_q, so it needs no reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            pend_row_q[b]  <= pend_row_d[b];
            pend_data_q[b] <= pend_data_d[b];
        end
    end

    // Array contents are not reset; reset still blocks any write in its cycle
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (!rst && arr_we[b]) begin
                mem_q[b][arr_row[b]] <= arr_data[b];
            end
        end
    end

    assign rd_data_lo  = rd_data_lo_q;
    assign rd_data_hi  = rd_data_hi_q;
    assign rd_valid    = rd_valid_q;
    assign rd_hi_retry = rd_hi_retry_q;
    assign pend_busy   = pend_busy_q;

endmodule

// File: tb/tb_dccm_bank_mem.sv
// Directed self-checking bench for dccm_bank_mem: direct writes, pending
// capture/retire, write stall, forwarding, lo/hi retry, freeze and reset.
module tb_dccm_bank_mem;

    localparam int unsigned DW = 39;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          freeze;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr_lo;
    logic [AW-1:0] rd_addr_hi;
    logic [DW-1:0] rd_data_lo;
    logic [DW-1:0] rd_data_hi;
    logic          rd_valid;
    logic          rd_hi_retry;
    logic          pend_busy;

    int checks   = 0;
    int failures = 0;

    dccm_bank_mem dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_en       (rd_en),
        .rd_addr_lo  (rd_addr_lo),
        .rd_addr_hi  (rd_addr_hi),
        .rd_data_lo  (rd_data_lo),
        .rd_data_hi  (rd_data_hi),
        .rd_valid    (rd_valid),
        .rd_hi_retry (rd_hi_retry),
        .pend_busy   (pend_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input logic en, input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        rd_en      = en;
        rd_addr_lo = lo;
        rd_addr_hi = hi;
    endtask

    task automatic set_wr(input logic en, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_en   = en;
        wr_addr = addr;
        wr_data = data;
    endtask

    initial begin
        rst    = 1'b1;
        freeze = 1'b0;
        set_rd(1'b0, 16'h0000, 16'h0000);
        set_wr(1'b0, 16'h0000, 39'h0);
        tick();
        tick();
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_retry", 64'(rd_hi_retry), 64'd0);
        check("rst_lo", 64'(rd_data_lo), 64'd0);
        check("rst_hi", 64'(rd_data_hi), 64'd0);
        check("rst_pbusy", 64'(pend_busy), 64'd0);
        rst = 1'b0;

        // Direct write to idle bank1, then read it back
        set_wr(1'b1, 16'h0004, 39'h12);
        #1 check("w1_ready", 64'(wr_ready), 64'd1);
        tick();
        check("w1_pbusy", 64'(pend_busy), 64'd0);
        check("w1_novalid", 64'(rd_valid), 64'd0);
        set_wr(1'b0, 16'h0000, 39'h0);
        set_rd(1'b1, 16'h0004, 16'h0004);
        tick();
        check("r1_valid", 64'(rd_valid), 64'd1);
        check("r1_lo", 64'(rd_data_lo), 64'h12);
        check("r1_hi", 64'(rd_data_hi), 64'h12);
        check("r1_retry", 64'(rd_hi_retry), 64'd0);
        check("r1_pbusy", 64'(pend_busy), 64'd0);

        // Write into read-busy bank2 goes to pending, retires on idle cycle
        set_rd(1'b1, 16'h0008, 16'h0008);
        set_wr(1'b1, 16'h0018, 39'h55);
        #1 check("pend_ready", 64'(wr_ready), 64'd1);
        tick();
        check("pend_pbusy", 64'(pend_busy), 64'd1);
        check("pend_valid", 64'(rd_valid), 64'd1);
        set_rd(1'b0, 16'h0000, 16'h0000);
        set_wr(1'b0, 16'h0000, 39'h0);
        tick();
        check("retire_pbusy", 64'(pend_busy), 64'd0);
        check("idle_valid", 64'(rd_valid), 64'd0);
        set_rd(1'b1, 16'h0018, 16'h0018);
        tick();
        check("retire_data", 64'(rd_data_lo), 64'h55);

        // Stall: bank2 read-busy with pending entry refuses another write
        set_rd(1'b1, 16'h0008, 16'h0008);
        set_wr(1'b1, 16'h0028, 39'h66);
        #1 check("stall_a_ready", 64'(wr_ready), 64'd1);
        tick();
        check("stall_a_pbusy", 64'(pend_busy), 64'd1);
        set_wr(1'b1, 16'h0018, 39'h99);
        #1 check("stall_b_ready", 64'(wr_ready), 64'd0);
        tick();
        check("stall_b_pbusy", 64'(pend_busy), 64'd1);
        set_rd(1'b0, 16'h0000, 16'h0000);
        #1 check("stall_c_ready", 64'(wr_ready), 64'd1);
        tick();
        check("stall_c_pbusy", 64'(pend_busy), 64'd1);
        set_wr(1'b0, 16'h0000, 39'h0);
        tick();
        check("stall_d_pbusy", 64'(pend_busy), 64'd0);
        set_rd(1'b1, 16'h0018, 16'h0018);
        tick();
        check("reissue_lo", 64'(rd_data_lo), 64'h99);
        check("reissue_hi", 64'(rd_data_hi), 64'h99);

        // Same bank, different rows: lo served, hi holds and retry flags
        set_rd(1'b1, 16'h0018, 16'h0028);
        tick();
        check("b2_retry", 64'(rd_hi_retry), 64'd1);
        check("b2_retry_lo", 64'(rd_data_lo), 64'h99);
        check("b2_retry_hi", 64'(rd_data_hi), 64'h99);
        set_rd(1'b1, 16'h0028, 16'h0028);
        tick();
        check("b2_row2_lo", 64'(rd_data_lo), 64'h66);
        check("b2_row2_hi", 64'(rd_data_hi), 64'h66);
        check("b2_row2_retry", 64'(rd_hi_retry), 64'd0);

        // Forwarding from pending entry while bank stays read-busy
        set_rd(1'b1, 16'h0008, 16'h0008);
        set_wr(1'b1, 16'h0018, 39'h77);
        tick();
        set_wr(1'b0, 16'h0000, 39'h0);
        set_rd(1'b1, 16'h0018, 16'h0018);
        tick();
        check("fwd_lo", 64'(rd_data_lo), 64'h77);
        check("fwd_hi", 64'(rd_data_hi), 64'h77);
        check("fwd_pbusy", 64'(pend_busy), 64'd1);
        set_rd(1'b0, 16'h0000, 16'h0000);
        tick();
        check("fwd_retire_pbusy", 64'(pend_busy), 64'd0);

        // Same-cycle write to the row being read returns the old value
        set_rd(1'b1, 16'h0004, 16'h0004);
        set_wr(1'b1, 16'h0004, 39'h34);
        tick();
        check("prewrite_lo", 64'(rd_data_lo), 64'h12);
        set_rd(1'b0, 16'h0000, 16'h0000);
        set_wr(1'b0, 16'h0000, 39'h0);
        tick();
        set_rd(1'b1, 16'h0004, 16'h0004);
        tick();
        check("postwrite_lo", 64'(rd_data_lo), 64'h34);

        // Bank1 rows 0/1 conflict, then identical addresses
        set_rd(1'b1, 16'h0004, 16'h0014);
        tick();
        check("b1_retry", 64'(rd_hi_retry), 64'd1);
        check("b1_retry_lo", 64'(rd_data_lo), 64'h34);
        check("b1_retry_hi", 64'(rd_data_hi), 64'h34);
        set_rd(1'b1, 16'h0004, 16'h0004);
        tick();
        check("b1_same_retry", 64'(rd_hi_retry), 64'd0);
        check("b1_same_hi", 64'(rd_data_hi), 64'h34);

        // Different banks on lo and hi
        set_rd(1'b1, 16'h0004, 16'h0018);
        tick();
        check("xbank_lo", 64'(rd_data_lo), 64'h34);
        check("xbank_hi", 64'(rd_data_hi), 64'h77);

        // Freeze holds outputs while a write still lands
        set_rd(1'b1, 16'h0018, 16'h0004);
        tick();
        check("prefrz_lo", 64'(rd_data_lo), 64'h77);
        freeze = 1'b1;
        set_rd(1'b1, 16'h0004, 16'h0018);
        set_wr(1'b1, 16'h000C, 39'h3C);
        #1 check("frz_wready", 64'(wr_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            set_wr(1'b0, 16'h0000, 39'h0);
            check("frz_valid", 64'(rd_valid), 64'd1);
            check("frz_lo", 64'(rd_data_lo), 64'h77);
            check("frz_hi", 64'(rd_data_hi), 64'h34);
        end
        freeze = 1'b0;
        set_rd(1'b0, 16'h0000, 16'h0000);
        tick();
        check("unfrz_valid", 64'(rd_valid), 64'd0);
        set_rd(1'b1, 16'h000C, 16'h000C);
        tick();
        check("frz_write_lo", 64'(rd_data_lo), 64'h3C);

        // Reset drops a pending write
        set_rd(1'b1, 16'h0008, 16'h0008);
        set_wr(1'b1, 16'h0018, 39'hAB);
        tick();
        check("prerst_pbusy", 64'(pend_busy), 64'd1);
        rst = 1'b1;
        set_rd(1'b0, 16'h0000, 16'h0000);
        set_wr(1'b0, 16'h0000, 39'h0);
        tick();
        check("rst2_pbusy", 64'(pend_busy), 64'd0);
        check("rst2_valid", 64'(rd_valid), 64'd0);
        check("rst2_lo", 64'(rd_data_lo), 64'd0);
        rst = 1'b0;
        set_rd(1'b1, 16'h0018, 16'h0018);
        tick();
        check("lost_write_lo", 64'(rd_data_lo), 64'h77);
        check("lost_write_valid", 64'(rd_valid), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
